// File: rtl/mux_scan_pkg.sv
// Shared helpers for the time-multiplexed channel scanner.
// Width helpers and the one-hot channel select encoder.
package mux_scan_pkg;

    localparam int MAX_CH = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Out-of-range index yields all-zero, so a bad index can never light two pins
    function automatic logic [MAX_CH-1:0] onehot(
        input int unsigned index,
        input int unsigned n
    );
        if (index < n)
            return MAX_CH'(1) << index;
        return '0;
    endfunction

endpackage

// File: rtl/mux_scan_tick_gen.sv
// Prescaler: pulses tick once every DIV enabled clocks.
// The count freezes while en is low and resumes where it stopped.
module tick_gen
    import mux_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk_out,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cnt_w(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_out) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/mux_scan.sv
// Time-multiplexing scanner: rotates CHANNELS words onto w with one-hot sel.
// Define MUX_SCAN_DEADTIME_EN to insert one blank cycle between channels.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 4
) (
    input  logic                        clk_out,
    input  logic                        rst,
    input  logic                        en,
    input  logic [CHANNELS*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]            w,
    output logic [CHANNELS-1:0]         sel,
    output logic [$clog2(CHANNELS)-1:0] idx,
    output logic                        wrap
);

    localparam int IDX_W = idx_w(CHANNELS);

    logic [IDX_W-1:0] index;
    logic             tick;
    logic             blank;
    logic             run;
    logic             pend;

`ifdef MUX_SCAN_DEADTIME_EN
    // tick cannot fire while blank is set, so the flag lasts exactly one clock
    always_ff @(posedge clk_out) begin
        if (rst)
            blank <= 1'b0;
        else
            blank <= tick;
    end
`else
    assign blank = 1'b0;
`endif

    assign run = en && !blank;

    tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_out(clk_out),
        .rst    (rst),
        .en     (run),
        .tick   (tick)
    );

    always_ff @(posedge clk_out) begin
        if (rst)
            index <= '0;
        else if (tick)
            index <= (index == IDX_W'(CHANNELS - 1)) ? '0 : index + IDX_W'(1);
    end

    // pend remembers a CHANNELS-1 -> 0 advance until channel 0 is actually shown
    always_ff @(posedge clk_out) begin
        if (rst) begin
            w    <= '0;
            sel  <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (run) begin
                w   <= data[int'(index)*WIDTH +: WIDTH];
                sel <= CHANNELS'(onehot(32'(index), CHANNELS));
                idx <= index;
            end else begin
                w   <= '0;
                sel <= '0;
            end
            wrap <= run && pend && (index == '0);
            if (tick && (index == IDX_W'(CHANNELS - 1)))
                pend <= 1'b1;
            else if (run && (index == '0))
                pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan (default and 3-channel/DIV=1 instances).
// Expected pattern follows MUX_SCAN_DEADTIME_EN when defined.
module tb_mux_scan;

`ifdef MUX_SCAN_DEADTIME_EN
    localparam int DT = 1;
`else
    localparam int DT = 0;
`endif

    logic        clk_out = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  w;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic        wrap;

    logic [23:0] data3;
    logic [7:0]  w3;
    logic [2:0]  sel3;
    logic [1:0]  idx3;
    logic        wrap3;

    int tests = 0;
    int fails = 0;

    always #5 clk_out = ~clk_out;

    mux_scan dut (
        .clk_out(clk_out),
        .rst    (rst),
        .en     (en),
        .data   (data),
        .w      (w),
        .sel    (sel),
        .idx    (idx),
        .wrap   (wrap)
    );

    mux_scan #(
        .WIDTH   (8),
        .CHANNELS(3),
        .DIV     (1)
    ) dut3 (
        .clk_out(clk_out),
        .rst    (rst),
        .en     (en),
        .data   (data3),
        .w      (w3),
        .sel    (sel3),
        .idx    (idx3),
        .wrap   (wrap3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // channel shown after edge n since release, -1 for a blank cycle
    function automatic int exp_ch(input int n, input int div, input int nch);
        int per;
        int pos;
        per = div + DT;
        pos = (n - 1) % per;
        if (pos >= div)
            return -1;
        return ((n - 1) / per) % nch;
    endfunction

    function automatic logic exp_wrap(input int n, input int div, input int nch);
        int per;
        per = div + DT;
        return (n > 1) && (((n - 1) % per) == 0) && (exp_ch(n, div, nch) == 0);
    endfunction

    task automatic step();
        @(posedge clk_out);
        #1;
    endtask

    task automatic check4(input int n);
        int          c;
        logic [15:0] sh;
        c  = exp_ch(n, 4, 4);
        sh = data >> (4 * ((c < 0) ? 0 : c));
        check($sformatf("w n=%0d", n), 32'(w), (c < 0) ? 32'd0 : 32'(sh[3:0]));
        check($sformatf("sel n=%0d", n), 32'(sel), (c < 0) ? 32'd0 : 32'd1 << c);
        check($sformatf("wrap n=%0d", n), 32'(wrap), 32'(exp_wrap(n, 4, 4)));
        check($sformatf("onehot0 n=%0d", n), 32'($onehot0(sel)), 32'd1);
        if (c >= 0)
            check($sformatf("idx n=%0d", n), 32'(idx), 32'(c));
    endtask

    task automatic check3(input int n);
        int          c;
        logic [23:0] sh;
        c  = exp_ch(n, 1, 3);
        sh = data3 >> (8 * ((c < 0) ? 0 : c));
        check($sformatf("w3 n=%0d", n), 32'(w3), (c < 0) ? 32'd0 : 32'(sh[7:0]));
        check($sformatf("sel3 n=%0d", n), 32'(sel3), (c < 0) ? 32'd0 : 32'd1 << c);
        check($sformatf("wrap3 n=%0d", n), 32'(wrap3), 32'(exp_wrap(n, 1, 3)));
        check($sformatf("idx3<3 n=%0d", n), 32'(idx3 < 2'd3), 32'd1);
        if (c >= 0)
            check($sformatf("idx3 n=%0d", n), 32'(idx3), 32'(c));
    endtask

    initial begin
        int  k;
        bit  found;

        rst   = 1'b1;
        en    = 1'b1;
        data  = 16'hDCBA;
        data3 = 24'h332211;
        step();
        step();
        check("rst w", 32'(w), 0);
        check("rst sel", 32'(sel), 0);
        check("rst idx", 32'(idx), 0);
        check("rst wrap", 32'(wrap), 0);
        check("rst w3", 32'(w3), 0);
        check("rst sel3", 32'(sel3), 0);

        rst = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            step();
            check4(n);
            check3(n);
        end

        // bring scan to channel 2, then reset mid-slot
        rst = 1'b1;
        step();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (sel == 4'b0100)
                found = 1'b1;
        end
        check("reach ch2", 32'(found), 1);
        rst = 1'b1;
        step();
        check("midrst w", 32'(w), 0);
        check("midrst sel", 32'(sel), 0);
        check("midrst idx", 32'(idx), 0);
        check("midrst wrap", 32'(wrap), 0);
        rst = 1'b0;
        for (int n = 1; n <= 6 + DT; n++) begin
            step();
            check4(n);
        end

        // now at channel 1 with count 2: freeze for 10 clocks
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold sel", 32'(sel), 0);
            check("hold w", 32'(w), 0);
            check("hold idx", 32'(idx), 1);
            check("hold wrap", 32'(wrap), 0);
        end
        en = 1'b1;
        k = 7 + DT;
        for (int i = 0; i < 4; i++) begin
            step();
            check4(k + i);
        end

        // live data tracking within slot 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        data[3:0] = 4'h5;
        step();
        check("live w", 32'(w), 32'h5);
        check("live sel", 32'(sel), 32'h1);
        data = 16'hDCBA;
        step();
        check("live restore w", 32'(w), 32'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
